bram0_loader: RTL
=================

# bram0_loader

Upstream fill stage for the BRAM accumulate path. Accepts a stream of IN_DATA_WIDTH-bit samples over a valid/ready handshake, packs LANES = DWIDTH/IN_DATA_WIDTH samples per BRAM0 row, and writes the rows from address 0 upward. On completion it pulses `run_start_o` with the written row count, which feeds the accessor's `start_run_i` / `run_count_i` directly.

## Interface
- CNT_BIT, 31, width of sample and row counters.
- DWIDTH, 32, BRAM0 row width.
- IN_DATA_WIDTH, 8, sample width. DWIDTH must be an integer multiple; LANES = DWIDTH/IN_DATA_WIDTH (4 by default).
- AWIDTH, 12, BRAM0 address width.
- MEM_SIZE, 4096, BRAM0 depth in rows; must be ≤ 2^AWIDTH.

Ports:
- clk  in  1  clock. Single clock domain; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start_load_i  in  1  start request; sampled only in IDLE.
- load_count_i  in  CNT_BIT  number of samples to load; latched on start.
- s_valid_i  in  1  sample valid.
- s_data_i  in  IN_DATA_WIDTH  sample data.
- s_ready_o  out  1  ready for a sample; high only in LOAD.
- idle_o / load_o / done_o  out  1 each  one-hot state flags.
- addr_b0_o  out  AWIDTH  BRAM0 address.
- ce_b0_o  out  1  BRAM0 chip enable.
- we_b0_o  out  1  BRAM0 write enable.
- d_b0_o  out  DWIDTH  BRAM0 write data.
- run_start_o  out  1  one-cycle start pulse to the accessor.
- run_count_o  out  CNT_BIT  rows written; held stable from DONE until the next accepted start.

## Operation
- States are IDLE, LOAD, LAST_WR and DONE.
  - `idle_o` = IDLE.
  - `load_o` = LOAD or LAST_WR.
  - `done_o` = DONE.
- IDLE + start_load_i:
  - Latch N = min(load_count_i, MEM_SIZE*LANES).
  - Clear lane, sample and row counters.
  - N = 0: go to DONE with run_count_o = 0.
  - N > 0: go to LOAD.
- start_load_i outside IDLE is ignored.
- LOAD:
  - `s_ready_o` = 1.
  - A handshake (s_valid_i & s_ready_o) stores s_data_i into lane L, bits [L*IN_DATA_WIDTH +: IN_DATA_WIDTH]. Lane 0 is the least significant.
- Row write:
  - Triggered by a handshake on lane LANES-1 or on the Nth sample.
  - The next cycle shows ce_b0_o = we_b0_o = 1, addr_b0_o = row index, d_b0_o = packed row.
  - Lanes not filled in the final partial row are zero.
  - The lane register clears and the row index increments.
- Nth-sample handshake: transition LOAD → LAST_WR. `s_ready_o` drops in the same edge, so no sample N+1 is accepted. LAST_WR is the cycle that carries the final row write.
- LAST_WR → DONE.
- DONE:
  - Lasts 1 cycle.
  - `run_start_o` = 1 only if run_count_o > 0.
  - Returns to IDLE.
- Row count = ceil(N/LANES), computed in CNT_BIT+1 bits to avoid overflow.
- ce/we/d/addr are registered. ce_b0_o is 0 in every cycle without a write; addr_b0_o and d_b0_o hold their last values.
- No reads are issued; BRAM0 is write-only from this block.
- reset in any state:
  - Next state is IDLE; all counters are cleared.
  - No further writes; an in-flight row write is dropped.
  - BRAM0 contents are untouched.

## Timing
- Reset values: idle_o = 1. All other outputs are 0, including s_ready_o, ce_b0_o, we_b0_o, run_start_o, addr_b0_o, d_b0_o and run_count_o.
- start_load_i sampled at edge t:
  - load_o = 1 and s_ready_o = 1 from cycle t+1.
  - For N = 0, done_o = 1 at t+1.
- Throughput is 1 sample/cycle with no back-pressure inside LOAD; a row write never stalls input.
- Last sample accepted at edge k: the write is visible in cycle k+1 (LAST_WR), and done_o and run_start_o are visible in cycle k+2.
- The accessor therefore sees run_start_o only after every row write has completed.
- idle_o returns at k+3. A new start_load_i is accepted at or after that edge.
- Gaps in s_valid_i: the lane holds and no spurious writes occur.

## Test plan
- N = 8, samples 0x01..0x08 back-to-back:
  - Row 0 = 0x04030201, row 1 = 0x08070605.
  - Exactly 2 cycles with we_b0_o = 1.
  - done_o for one cycle with run_count_o = 2.
  - run_start_o pulses once.
- N = 5, samples 0x11..0x15: row 1 = 0x00000015, run_count_o = 2, s_ready_o = 0 from the cycle after the 5th handshake.
- N = 8 with random s_valid_i gaps: identical row contents and addresses as the first case, and ce_b0_o = 0 in every gap cycle.
- N = 0: done_o at t+1, no writes, run_start_o stays 0, idle_o at t+2.
- Overflow, N = 9:
  - start_load_i pulsed again during LOAD: ignored.
  - reset asserted after 6 samples: idle_o = 1 next cycle, no further ce_b0_o, no done_o.
- Clamp, with MEM_SIZE = 2 and N = 20: exactly 8 samples accepted, rows 0–1 written, run_count_o = 2, and sample 9 is never handshaken.

Source files
------------

// File: rtl/bram0_loader_if.sv
// Handshake, control and BRAM0 write bus between the sample source and bram0_loader.
// The master modport is the upstream source and the accessor; the slave modport is the loader.
interface bram0_loader_if #(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH        = 32,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 12
);
  logic                     start_load_i;
  logic [CNT_BIT-1:0]       load_count_i;
  logic                     s_valid_i;
  logic [IN_DATA_WIDTH-1:0] s_data_i;
  logic                     s_ready_o;
  logic                     idle_o;
  logic                     load_o;
  logic                     done_o;
  logic [AWIDTH-1:0]        addr_b0_o;
  logic                     ce_b0_o;
  logic                     we_b0_o;
  logic [DWIDTH-1:0]        d_b0_o;
  logic                     run_start_o;
  logic [CNT_BIT-1:0]       run_count_o;

  modport master (
    output start_load_i, load_count_i, s_valid_i, s_data_i,
    input  s_ready_o, idle_o, load_o, done_o, addr_b0_o, ce_b0_o, we_b0_o,
           d_b0_o, run_start_o, run_count_o
  );

  modport slave (
    input  start_load_i, load_count_i, s_valid_i, s_data_i,
    output s_ready_o, idle_o, load_o, done_o, addr_b0_o, ce_b0_o, we_b0_o,
           d_b0_o, run_start_o, run_count_o
  );
endinterface

// File: rtl/bram0_loader.sv
// Packs a sample stream into DWIDTH-bit rows and writes them to BRAM0 from address 0,
// then pulses run_start_o with the row count for the accessor.
module bram0_loader #(
  parameter int CNT_BIT       = 31,
  parameter int DWIDTH        = 32,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 12,
  parameter int MEM_SIZE      = 4096
) (
  input  logic           clk,
  input  logic           reset,
  bram0_loader_if.slave  bus
);
  localparam int LANES  = DWIDTH / IN_DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_BIT:0]    MAX_N     = (CNT_BIT+1)'(MEM_SIZE * LANES);
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, LAST_WR, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_BIT-1:0] n_q;
  logic [CNT_BIT-1:0] smp_cnt;
  logic [CNT_BIT-1:0] run_count;
  logic [CNT_BIT-1:0] n_start;
  logic [LANE_W-1:0]  lane;
  logic [AWIDTH-1:0]  row;
  logic [AWIDTH-1:0]  addr;
  logic [DWIDTH-1:0]  row_buf;
  logic [DWIDTH-1:0]  row_ins;
  logic [DWIDTH-1:0]  d;
  logic               ce;
  logic               hs;
  logic               last_smp;
  logic               row_full;

  function automatic logic [CNT_BIT-1:0] clamp_count(input logic [CNT_BIT-1:0] req);
    logic [CNT_BIT:0] wide;
    wide = {1'b0, req};
    return (wide > MAX_N) ? MAX_N[CNT_BIT-1:0] : req;
  endfunction

  // Extra headroom bit keeps n + LANES-1 from wrapping near the top of the counter range.
  function automatic logic [CNT_BIT-1:0] ceil_rows(input logic [CNT_BIT-1:0] n);
    logic [CNT_BIT:0] wide;
    wide = ({1'b0, n} + (CNT_BIT+1)'(LANES - 1)) / (CNT_BIT+1)'(LANES);
    return wide[CNT_BIT-1:0];
  endfunction

  assign n_start  = clamp_count(bus.load_count_i);
  assign hs       = bus.s_valid_i && (state == LOAD);
  assign last_smp = (smp_cnt == n_q - CNT_BIT'(1));
  assign row_full = (lane == LAST_LANE);

  always_comb begin
    row_ins = row_buf;
    row_ins[lane*IN_DATA_WIDTH +: IN_DATA_WIDTH] = bus.s_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_load_i) state_nxt = (n_start == '0) ? DONE : LOAD;
      LOAD:    if (hs && last_smp)   state_nxt = LAST_WR;
      LAST_WR: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept stage: the completed row is registered onto the BRAM0 port in the handshake edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q       <= '0;
      smp_cnt   <= '0;
      lane      <= '0;
      row       <= '0;
      ce        <= 1'b0;
      addr      <= '0;
      d         <= '0;
      run_count <= '0;
    end else begin
      ce <= 1'b0;
      if (state == IDLE && bus.start_load_i) begin
        n_q       <= n_start;
        smp_cnt   <= '0;
        lane      <= '0;
        row       <= '0;
        row_buf   <= '0;
        run_count <= ceil_rows(n_start);
      end
      if (hs) begin
        smp_cnt <= smp_cnt + CNT_BIT'(1);
        if (row_full || last_smp) begin
          ce      <= 1'b1;
          addr    <= row;
          d       <= row_ins;
          row     <= row + AWIDTH'(1);
          lane    <= '0;
          row_buf <= '0;
        end else begin
          lane    <= lane + LANE_W'(1);
          row_buf <= row_ins;
        end
      end
    end
  end

  assign bus.s_ready_o   = (state == LOAD);
  assign bus.idle_o      = (state == IDLE);
  assign bus.load_o      = (state == LOAD) || (state == LAST_WR);
  assign bus.done_o      = (state == DONE);
  assign bus.run_start_o = (state == DONE) && (run_count != '0);
  assign bus.run_count_o = run_count;
  assign bus.ce_b0_o     = ce;
  assign bus.we_b0_o     = ce;
  assign bus.addr_b0_o   = addr;
  assign bus.d_b0_o      = d;
endmodule
